// File: rtl/inverse_low_pass_filter_pkg.sv
// Shared types and constants for the inverse low-pass filter and its helpers.
package filter_pkg;

  localparam int W_DEF = 20;
  localparam int K_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(W_DEF);
  localparam longint SAT_MIN = sat_min(W_DEF);

endpackage

// File: rtl/inverse_low_pass_filter_strobe_sync.sv
// Multi-stage synchroniser for an asynchronous strobe, followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_old;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_old  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_old  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_old;

endmodule

// File: rtl/inverse_low_pass_filter.sv
// Undoes a first-order IIR low-pass: x[n] = (y[n] - y[n-1] + (y[n-1]>>>k)) <<< k,
// clipped to W bits, one result per accepted clk_in rising edge.
module inverse_low_pass_filter
  import filter_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                qzt_clk,
  input  logic                rst_n,
  input  logic                clk_in,
  input  logic [K_W-1:0]      k,
  input  logic signed [W-1:0] Vin,
  output logic signed [W-1:0] Vout,
  output logic                Vout_valid,
  output logic                sat,
  output logic                overrun
);

  localparam int PW = W + 17;
  localparam logic signed [PW-1:0] L_MAX = PW'(sat_max(W));
  localparam logic signed [PW-1:0] L_MIN = PW'(sat_min(W));

  state_t              r_state;
  state_t              w_next;
  logic                w_edge;
  logic signed [W-1:0] r_y_cur;
  logic signed [W-1:0] r_y_prev;
  logic [K_W-1:0]      r_k_lat;

  logic signed [W-1:0]  w_y_shr;
  logic signed [W:0]    w_d;
  logic signed [W+1:0]  w_t;
  logic signed [PW-1:0] w_p;
  logic                 w_hi;
  logic                 w_lo;
  logic signed [W-1:0]  w_clip;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (qzt_clk),
    .rst_n   (rst_n),
    .i_async (clk_in),
    .o_edge  (w_edge)
  );

  // Full-precision datapath; widths chosen so nothing wraps before the clip.
  assign w_y_shr = r_y_prev >>> r_k_lat;
  assign w_d     = (W+1)'(r_y_cur) - (W+1)'(r_y_prev);
  assign w_t     = (W+2)'(w_d) + (W+2)'(w_y_shr);
  assign w_p     = PW'(w_t) <<< r_k_lat;
  assign w_hi    = (w_p > L_MAX);
  assign w_lo    = (w_p < L_MIN);
  assign w_clip  = w_hi ? L_MAX[W-1:0] : (w_lo ? L_MIN[W-1:0] : w_p[W-1:0]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_edge) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_COMPUTE;
      ST_COMPUTE: w_next = ST_OUTPUT;
      ST_OUTPUT:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_y_cur    <= '0;
      r_y_prev   <= '0;
      r_k_lat    <= '0;
      Vout       <= '0;
      Vout_valid <= 1'b0;
      sat        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_state    <= w_next;
      Vout_valid <= (r_state == ST_COMPUTE);
      if (w_edge && (r_state != ST_IDLE)) overrun <= 1'b1;
      case (r_state)
        ST_CAPTURE: begin
          r_y_cur <= Vin;
          r_k_lat <= k;
        end
        // Result lands as the FSM enters OUTPUT, so Vout_valid and Vout
        // are visible together three cycles after the edge.
        ST_COMPUTE: begin
          Vout <= w_clip;
          sat  <= w_hi | w_lo;
        end
        ST_OUTPUT: r_y_prev <= r_y_cur;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_low_pass_filter.sv
// Self-checking bench: directed vector table, overrun and reset corner cases,
// then randomized strobes compared against an arithmetic reference model.
module tb_inverse_low_pass_filter;

  localparam int W = 20;

  logic                qzt_clk = 1'b0;
  logic                rst_n   = 1'b0;
  logic                clk_in  = 1'b0;
  logic [3:0]          k       = '0;
  logic signed [W-1:0] Vin     = '0;
  logic signed [W-1:0] Vout;
  logic                Vout_valid;
  logic                sat;
  logic                overrun;

  int     checks   = 0;
  int     failures = 0;
  longint yp       = 0;

  inverse_low_pass_filter #(.W(W), .SYNC_STAGES(2)) dut (
    .qzt_clk    (qzt_clk),
    .rst_n      (rst_n),
    .clk_in     (clk_in),
    .k          (k),
    .Vin        (Vin),
    .Vout       (Vout),
    .Vout_valid (Vout_valid),
    .sat        (sat),
    .overrun    (overrun)
  );

  always #5 qzt_clk = ~qzt_clk;

  typedef struct {
    bit     rst;
    int     kk;
    longint vin;
    longint exp_v;
    bit     exp_s;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic longint model(input int kk, input longint y, output bit s);
    longint x;
    x = ((y - yp) + (yp >>> kk)) <<< kk;
    s = 1'b0;
    if (x > 524287) begin
      x = 524287;
      s = 1'b1;
    end else if (x < -524288) begin
      x = -524288;
      s = 1'b1;
    end
    return x;
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    clk_in = 1'b0;
    repeat (2) @(negedge qzt_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge qzt_clk);
    yp = 0;
  endtask

  // Starts at a negedge; Vout_valid is expected at the 5th negedge afterwards.
  task automatic strobe(input int kk, input longint v, input bit scramble,
                        output int first, output int npulse);
    Vin    = W'(v);
    k      = 4'(kk);
    clk_in = 1'b1;
    first  = -1;
    npulse = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge qzt_clk);
      if (Vout_valid) begin
        npulse++;
        if (first < 0) first = i;
      end
      if (scramble && i == 4) begin
        k   = 4'($urandom);
        Vin = W'($urandom);
      end
      if (i == 6) clk_in = 1'b0;
    end
  endtask

  task automatic run_one(input string tag, input int kk, input longint v,
                         input longint ev, input bit es, input bit scramble);
    int first, npulse;
    strobe(kk, v, scramble, first, npulse);
    chk({tag, "_latency"}, first, 5);
    chk({tag, "_pulses"}, npulse, 1);
    chk({tag, "_vout"}, longint'(Vout), ev);
    chk({tag, "_sat"}, longint'(sat), longint'(es));
    yp = v;
  endtask

  initial begin
    int     npulse;
    longint ev;
    bit     es;

    tbl[0]  = '{1'b1, 0,  1000,    1000,    1'b0};
    tbl[1]  = '{1'b0, 0,  -2000,   -2000,   1'b0};
    tbl[2]  = '{1'b1, 2,  1000,    4000,    1'b0};
    tbl[3]  = '{1'b0, 2,  1750,    4000,    1'b0};
    tbl[4]  = '{1'b1, 1,  -3,      -6,      1'b0};
    tbl[5]  = '{1'b0, 1,  -3,      -4,      1'b0};
    tbl[6]  = '{1'b1, 4,  100000,  524287,  1'b1};
    tbl[7]  = '{1'b0, 4,  100000,  100000,  1'b0};
    tbl[8]  = '{1'b0, 4,  -100000, -524288, 1'b1};
    tbl[9]  = '{1'b0, 0,  524287,  524287,  1'b0};
    tbl[10] = '{1'b0, 15, 1,       -524288, 1'b1};

    repeat (3) @(negedge qzt_clk);
    chk("reset_vout", longint'(Vout), 0);
    chk("reset_valid", longint'(Vout_valid), 0);
    chk("reset_sat", longint'(sat), 0);
    chk("reset_overrun", longint'(overrun), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge qzt_clk);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      run_one($sformatf("vec%0d", i), tbl[i].kk, tbl[i].vin,
              tbl[i].exp_v, tbl[i].exp_s, 1'b0);
    end
    chk("table_no_overrun", longint'(overrun), 0);

    // Two rising edges 2 cycles apart: second one lands in COMPUTE.
    ev     = model(3, 777, es);
    Vin    = W'(777);
    k      = 4'd3;
    npulse = 0;
    clk_in = 1'b1;
    @(negedge qzt_clk);
    clk_in = 1'b0;
    @(negedge qzt_clk);
    clk_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge qzt_clk);
      if (Vout_valid) npulse++;
      if (i == 4) clk_in = 1'b0;
    end
    chk("ovr_pulses", npulse, 1);
    chk("ovr_vout", longint'(Vout), ev);
    chk("ovr_flag", longint'(overrun), 1);
    yp = 777;
    ev = model(2, -5000, es);
    run_one("ovr_next", 2, -5000, ev, es, 1'b0);
    chk("ovr_sticky", longint'(overrun), 1);

    // Reset asserted while the FSM sits in COMPUTE.
    Vin    = W'(1234);
    k      = 4'd0;
    npulse = 0;
    clk_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge qzt_clk);
      if (Vout_valid) npulse++;
    end
    rst_n  = 1'b0;
    clk_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge qzt_clk);
      if (Vout_valid) npulse++;
    end
    chk("rstmid_vout", longint'(Vout), 0);
    chk("rstmid_sat", longint'(sat), 0);
    chk("rstmid_overrun", longint'(overrun), 0);
    rst_n = 1'b1;
    yp    = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge qzt_clk);
      if (Vout_valid) npulse++;
    end
    chk("rstmid_no_valid", npulse, 0);
    run_one("rstmid_after", 0, 5, 5, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int     kk;
      longint v;
      logic signed [W-1:0] raw;
      kk  = (n % 5 == 0) ? 0 : int'($urandom_range(0, 15));
      raw = W'($urandom);
      v   = (n % 3 == 0) ? longint'(raw >>> 8) : longint'(raw);
      ev  = model(kk, v, es);
      run_one($sformatf("rnd%0d", n), kk, v, ev, es, 1'b1);
    end
    chk("final_overrun", longint'(overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
